// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sa_pkg
// Description : Shared types for the systolic-array drain path: one psum
//               column word, one full output row, the deskew FSM state
//               encoding and the width helper for row counters.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    localparam int ADD_DATAWIDTH = 8;   // psum width per column, signed
    localparam int NUM_COLS      = 4;   // systolic width

    typedef logic [ADD_DATAWIDTH-1:0] psum_t;
    typedef psum_t [NUM_COLS-1:0]     row_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } deskew_state_e;

    // Bits needed to hold the values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_row_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sa_row_fifo
// Description : Synchronous FIFO of whole output rows. A push into a full
//               FIFO is accepted when a pop happens in the same cycle. The
//               head row is visible combinationally and reads as zero while
//               the FIFO is empty.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_push       - write i_data (honoured if not full or popping)
//               i_pop        - remove head (ignored when empty)
//               i_data       - row to write
//               o_data       - head row
//               o_full       - DEPTH rows stored
//               o_empty      - no rows stored
// Revision    : 1.0 - initial release
// ============================================================================
module sa_row_fifo
    import sa_pkg::*;
#(
    parameter int DEPTH = 8     // power of 2, >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  row_t i_data,
    output row_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = 1;

    row_t            r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic            w_do_push;
    logic            w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                       (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/sa_psum_deskew.sv
`default_nettype none
// ============================================================================
// Module      : sa_psum_deskew
// Description : Drain-side collector for the systolic array. Column c of the
//               psum stream lags column c-1 by one cycle; this block delays
//               each column so a whole row lines up, captures M rows after
//               i_start and buffers them in a row FIFO drained over
//               o_valid/i_ready.
// Config      : SA_DESKEW_RELU_EN - when defined, negative column values are
//               clamped to zero at the FIFO input; otherwise data is bit-exact.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               i_start     - one-cycle start pulse (ignored unless idle)
//               i_num_rows  - M, rows to capture, latched on i_start
//               i_psum      - skewed psum columns from the array
//               o_row       - aligned row at the FIFO head
//               o_valid     - o_row holds a row
//               i_ready     - consumer accepts o_row
//               o_busy      - capture/drain in progress
//               o_done      - one-cycle pulse when all rows are out
//               o_overflow  - sticky, a row was dropped on a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module sa_psum_deskew
    import sa_pkg::*;
#(
    parameter  int ARRAY_LAT  = 4,
    parameter  int FIFO_DEPTH = 8,
    parameter  int MAX_ROWS   = 255,
    localparam int CNT_W      = cnt_width(MAX_ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_num_rows,
    input  row_t             i_psum,
    output row_t             o_row,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow
);

    // WAIT is entered one cycle after i_start, so loading LAT+COLS-2 and
    // leaving when the count is about to reach zero makes the first CAPTURE
    // cycle coincide with the alignment of row 0.
    localparam int                 c_WAIT_W    = $clog2(ARRAY_LAT + NUM_COLS);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(ARRAY_LAT + NUM_COLS - 2);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE  = 1;
    localparam logic [CNT_W-1:0]   c_ROW_ONE   = 1;

    deskew_state_e       r_state;
    deskew_state_e       w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_num_rows;
    logic [CNT_W-1:0]    r_row_cnt;
    logic                r_overflow;

    row_t                w_aligned;
    row_t                w_fifo_in;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_last_row;

    // ------------------------------------------------------------------
    // Deskew: column c is delayed NUM_COLS-1-c cycles; last column is direct.
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int c_STAGES = NUM_COLS - 1 - c;
        if (c_STAGES == 0) begin : g_direct
            assign w_aligned[c] = i_psum[c];
        end else begin : g_delay
            psum_t r_dly [c_STAGES];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < c_STAGES; s++) r_dly[s] <= '0;
                end else begin
                    r_dly[0] <= i_psum[c];
                    for (int s = 1; s < c_STAGES; s++) r_dly[s] <= r_dly[s-1];
                end
            end
            assign w_aligned[c] = r_dly[c_STAGES-1];
        end
`ifdef SA_DESKEW_RELU_EN
        assign w_fifo_in[c] = w_aligned[c][ADD_DATAWIDTH-1] ? '0 : w_aligned[c];
`else
        assign w_fifo_in[c] = w_aligned[c];
`endif
    end

    // ------------------------------------------------------------------
    // Row FIFO
    // ------------------------------------------------------------------
    assign w_push = (r_state == CAPTURE);
    assign w_pop  = !w_fifo_empty && i_ready;
    assign w_drop = w_push && w_fifo_full && !w_pop;

    sa_row_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (i_ready),
        .i_data  (w_fifo_in),
        .o_data  (o_row),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign w_last_row = (r_row_cnt == (r_num_rows - c_ROW_ONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = (i_num_rows == '0) ? DRAIN : WAIT;
            WAIT:    if (r_wait_cnt <= c_WAIT_ONE) w_state_nxt = CAPTURE;
            CAPTURE: if (w_last_row) w_state_nxt = DRAIN;
            DRAIN:   if (w_fifo_empty) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_num_rows <= '0;
            r_row_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_num_rows <= i_num_rows;
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_row_cnt  <= '0;
                    end
                end
                WAIT: begin
                    if (r_wait_cnt != '0) r_wait_cnt <= r_wait_cnt - c_WAIT_ONE;
                end
                CAPTURE: begin
                    // Saturating so a stray extra cycle can never wrap to 0.
                    if (r_row_cnt != '1) r_row_cnt <= r_row_cnt + c_ROW_ONE;
                end
                default: ;
            endcase
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    assign o_valid    = !w_fifo_empty;
    assign o_busy     = (r_state != IDLE);
    assign o_done     = (r_state == DRAIN) && w_fifo_empty;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sa_psum_deskew.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_psum_deskew
// Description : Self-checking bench for sa_psum_deskew. Drives the skewed
//               psum stream from a table of intended rows following the array
//               timing contract (random filler elsewhere) and compares the
//               DUT every cycle with a queue-based model of the row FIFO and
//               transaction lifetime.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_psum_deskew;
    import sa_pkg::*;

    localparam int LAT   = 4;
    localparam int DEPTH = 8;
    localparam int ALIGN = LAT + NUM_COLS - 1;   // row 0 aligned at t0+ALIGN

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic [7:0] i_num_rows = '0;
    row_t       i_psum = '0;
    row_t       o_row;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic       o_overflow;

    always #5 clk = ~clk;

    sa_psum_deskew #(
        .ARRAY_LAT  (LAT),
        .FIFO_DEPTH (DEPTH),
        .MAX_ROWS   (255)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_num_rows (i_num_rows),
        .i_psum     (i_psum),
        .o_row      (o_row),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_overflow (o_overflow)
    );

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model state
    row_t data [16];
    row_t q [$];
    bit   act = 1'b0;
    bit   m_ovf = 1'b0;
    int   t0 = -1000;
    int   m_rows = 0;
    int   drain_cyc = 0;
    bit   exp_valid, exp_busy, exp_done;
    row_t exp_row;

    function automatic row_t clamp(input row_t r);
        row_t o = r;
`ifdef SA_DESKEW_RELU_EN
        for (int c = 0; c < NUM_COLS; c++) if (r[c][ADD_DATAWIDTH-1]) o[c] = '0;
`endif
        return o;
    endfunction

    task automatic model_expect();
        exp_valid = (q.size() != 0);
        exp_row   = exp_valid ? q[0] : '0;
        exp_busy  = act && (cyc > t0);
        exp_done  = act && (cyc >= drain_cyc) && (q.size() == 0);
    endtask

    task automatic report(input string name);
        $display("FAIL %s cyc=%0d got valid=%b row=%h busy=%b done=%b ovf=%b want valid=%b row=%h busy=%b done=%b ovf=%b",
                 name, cyc, o_valid, o_row, o_busy, o_done, o_overflow,
                 exp_valid, exp_row, exp_busy, exp_done, m_ovf);
    endtask

    // Drive one cycle of inputs, advance the model, then move to the next
    // sampling point (negedge after the clock edge).
    task automatic tick(input bit start, input int nrows, input bit ready, input bit rst_in);
        bit pop;
        bit done_now;
        int k;
        rst        = rst_in;
        i_start    = start;
        i_num_rows = 8'(nrows);
        i_ready    = ready;
        for (int c = 0; c < NUM_COLS; c++) begin
            k = cyc - t0 - LAT - c;
            if (act && k >= 0 && k < m_rows) i_psum[c] = data[k][c];
            else                             i_psum[c] = psum_t'($urandom);
        end
        if (rst_in) begin
            q.delete();
            act   = 1'b0;
            m_ovf = 1'b0;
        end else begin
            done_now = act && (cyc >= drain_cyc) && (q.size() == 0);
            pop = (q.size() != 0) && ready;
            if (pop) void'(q.pop_front());
            k = cyc - t0 - ALIGN;
            if (act && k >= 0 && k < m_rows) begin
                if (q.size() < DEPTH) q.push_back(clamp(data[k]));
                else                  m_ovf = 1'b1;
            end
            if (start && !act) begin
                act       = 1'b1;
                t0        = cyc;
                m_rows    = nrows;
                drain_cyc = (nrows == 0) ? cyc + 1 : cyc + ALIGN + nrows;
            end else if (done_now) begin
                act = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic fill_random();
        for (int m = 0; m < 16; m++)
            for (int c = 0; c < NUM_COLS; c++) data[m][c] = psum_t'($urandom);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int n = 0; n < 2; n++)
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 255), 1'($urandom_range(0, 1)), 1'b1);
        checks++;
        if (o_row !== '0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs row=%h valid=%b busy=%b done=%b ovf=%b want all 0",
                     o_row, o_valid, o_busy, o_done, o_overflow);
        end
        tick(1'b0, 0, 1'b1, 1'b0);
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b valid=%b want 0 0", o_busy, o_valid);
        end
    endtask

    task automatic test_aligned();
        int ts = cyc;
        int fv = -1;
        int fd = -1;
        for (int m = 0; m < 16; m++)
            for (int c = 0; c < NUM_COLS; c++) data[m][c] = psum_t'(10 * m + c);
        for (int n = 0; n < 16; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || (exp_valid && o_row !== exp_row) || o_busy !== exp_busy ||
                o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("aligned");
            end
            if (o_valid === 1'b1 && fv < 0) fv = cyc - ts;
            if (o_done === 1'b1 && fd < 0) fd = cyc - ts;
            tick(n == 0, 4, 1'b1, 1'b0);
        end
        checks++;
        if (fv != 8) begin failures++; $display("FAIL aligned_first_valid got t0+%0d want t0+8", fv); end
        checks++;
        if (fd != 12) begin failures++; $display("FAIL aligned_done got t0+%0d want t0+12", fd); end
    endtask

    task automatic test_backpressure();
        fill_random();
        for (int n = 0; n < 32; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || (exp_valid && o_row !== exp_row) || o_busy !== exp_busy ||
                o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("backpressure");
            end
            tick(n == 0, 4, n >= 20, 1'b0);
        end
        checks++;
        if (act || o_overflow !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_end pending=%b ovf=%b want 0 0", act, o_overflow);
        end
    endtask

    task automatic test_relu_col0();
        int seen = 0;
        psum_t want;
`ifdef SA_DESKEW_RELU_EN
        want = 8'h00;
`else
        want = 8'hF0;
`endif
        fill_random();
        for (int m = 0; m < 16; m++) data[m][0] = 8'hF0;
        for (int n = 0; n < 16; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || (exp_valid && o_row !== exp_row) || o_busy !== exp_busy ||
                o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("relu_col0");
            end
            if (o_valid === 1'b1) begin
                seen++;
                checks++;
                if (o_row[0] !== want) begin
                    failures++;
                    $display("FAIL relu_col0_value got %h want %h", o_row[0], want);
                end
            end
            tick(n == 0, 2, 1'b1, 1'b0);
        end
        checks++;
        if (seen != 2) begin failures++; $display("FAIL relu_col0_rows got %0d want 2", seen); end
    endtask

    task automatic test_zero_rows();
        int ts = cyc;
        int fd = -1;
        int nv = 0;
        for (int n = 0; n < 6; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || o_busy !== exp_busy || o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("zero_rows");
            end
            if (o_done === 1'b1 && fd < 0) fd = cyc - ts;
            if (o_valid === 1'b1) nv++;
            tick(n == 0, 0, 1'b1, 1'b0);
        end
        checks++;
        if (fd != 1 || nv != 0) begin
            failures++;
            $display("FAIL zero_rows done_at=t0+%0d valid_cycles=%0d want t0+1 and 0", fd, nv);
        end
    endtask

    task automatic test_overflow();
        fill_random();
        for (int n = 0; n < 40; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || (exp_valid && o_row !== exp_row) || o_busy !== exp_busy ||
                o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("overflow");
            end
            tick(n == 0, 10, n >= 24, 1'b0);
        end
        checks++;
        if (o_overflow !== 1'b1 || act) begin
            failures++;
            $display("FAIL overflow_end ovf=%b pending=%b want 1 0", o_overflow, act);
        end
    endtask

    task automatic test_reset_mid();
        int rows_out = 0;
        fill_random();
        for (int n = 0; n < 30; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || (exp_valid && o_row !== exp_row) || o_busy !== exp_busy ||
                o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("reset_mid");
            end
            if (n == 10) begin
                checks++;
                if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_mid_flush valid=%b busy=%b want 0 0", o_valid, o_busy);
                end
            end
            if (n >= 12 && o_valid === 1'b1) rows_out++;
            tick(n == 0 || n == 12, (n == 0) ? 6 : 2, 1'b1, n == 9);
        end
        checks++;
        if (rows_out != 2) begin failures++; $display("FAIL reset_mid_rows got %0d want 2", rows_out); end
    endtask

    task automatic test_back_to_back();
        fill_random();
        for (int n = 0; n < 300; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || (exp_valid && o_row !== exp_row) || o_busy !== exp_busy ||
                o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("back_to_back");
            end
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 12), $urandom_range(0, 9) < 7, 1'b0);
        end
        for (int n = 0; n < 60 && act; n++) begin
            model_expect();
            checks++;
            if (o_valid !== exp_valid || (exp_valid && o_row !== exp_row) || o_busy !== exp_busy ||
                o_done !== exp_done || o_overflow !== m_ovf) begin
                failures++;
                report("back_to_back_flush");
            end
            tick(1'b0, 0, 1'b1, 1'b0);
        end
        checks++;
        if (act) begin failures++; $display("FAIL back_to_back_timeout pending=%b want 0", act); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_aligned();
        test_backpressure();
        test_relu_col0();
        test_zero_rows();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
